// File: rtl/all_demod.sv
// Hard-decision demapper for BPSK/QPSK/8PSK/16QAM, two-stage valid/ready pipeline.
// Optional soft confidence output conf_out is enabled by defining SOFT_METRIC_EN.
module all_demod #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               select,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               bits_out,
  output logic [2:0]               nbits_out,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef SOFT_METRIC_EN
  output logic [3:0]               conf_out,
`endif
  output logic [CNT_W-1:0]         sym_cnt
);

  typedef enum logic [1:0] {
    SCH_BPSK  = 2'b00,
    SCH_QPSK  = 2'b01,
    SCH_8PSK  = 2'b10,
    SCH_QAM16 = 2'b11
  } scheme_e;

  localparam int AW = DATA_W + 1;  // magnitude width, holds |-2^(DATA_W-1)|
  localparam int MW = DATA_W + 2;  // room for 2*magnitude
  localparam logic signed [AW-1:0] QAM_T = AW'(4);

  // ---------------- flow control ----------------
  logic v1, v2, adv1, adv2;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // ---------------- stage 1: signs, magnitudes, QAM slicing ----------------
  logic signed [AW-1:0] i_ext, q_ext;
  logic [AW-1:0]        ai_c, aq_c;
  logic [1:0]           qi_c, qq_c;

  assign i_ext = {i_in[DATA_W-1], i_in};
  assign q_ext = {q_in[DATA_W-1], q_in};
  assign ai_c  = i_ext[AW-1] ? AW'(-i_ext) : AW'(i_ext);
  assign aq_c  = q_ext[AW-1] ? AW'(-q_ext) : AW'(q_ext);
  // Pair MSB is the sign half-plane, LSB marks the inner ring [-4, 3].
  assign qi_c  = {~i_ext[AW-1], (i_ext < QAM_T) && (i_ext >= -QAM_T)};
  assign qq_c  = {~q_ext[AW-1], (q_ext < QAM_T) && (q_ext >= -QAM_T)};

  scheme_e       sel1;
  logic          si1, sq1;
  logic [AW-1:0] ai1, aq1;
  logic [1:0]    qi1, qq1;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else if (adv1) v1 <= in_valid;
  end

  // NOTE: payload registers carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      sel1 <= scheme_e'(select);
      si1  <= i_ext[AW-1];
      sq1  <= q_ext[AW-1];
      ai1  <= ai_c;
      aq1  <= aq_c;
      qi1  <= qi_c;
      qq1  <= qq_c;
    end
  end

  // ---------------- stage 2: decision ----------------
  logic [MW-1:0] ai_w, aq_w, ai_x2, aq_x2;
  logic [2:0]    sector;
  logic [3:0]    dec_bits;
  logic [2:0]    dec_nbits;

  assign ai_w  = {1'b0, ai1};
  assign aq_w  = {1'b0, aq1};
  assign ai_x2 = {ai1, 1'b0};
  assign aq_x2 = {aq1, 1'b0};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    sector = 3'd0;
    // Axis tests come first so boundary ties fall into the axis sector.
    if (aq_x2 <= ai_w)      sector = si1 ? 3'd4 : 3'd0;
    else if (ai_x2 <= aq_w) sector = sq1 ? 3'd6 : 3'd2;
    else begin
      case ({si1, sq1})
        2'b00:   sector = 3'd1;
        2'b10:   sector = 3'd3;
        2'b11:   sector = 3'd5;
        default: sector = 3'd7;
      endcase
    end
  end

  always_comb begin
    dec_bits  = 4'd0;
    dec_nbits = 3'd0;
    case (sel1)
      SCH_BPSK: begin
        dec_bits  = {3'b000, si1};
        dec_nbits = 3'd1;
      end
      SCH_QPSK: begin
        dec_bits  = {2'b00, si1, sq1};
        dec_nbits = 3'd2;
      end
      SCH_8PSK: begin
        dec_bits  = {1'b0, sector ^ (sector >> 1)};
        dec_nbits = 3'd3;
      end
      default: begin
        dec_bits  = {qi1, qq1};
        dec_nbits = 3'd4;
      end
    endcase
  end

`ifdef SOFT_METRIC_EN
  localparam logic [MW-1:0] QAM_M = MW'(4);

  function automatic logic [MW-1:0] abs_diff(input logic [MW-1:0] a, input logic [MW-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [MW-1:0] min2(input logic [MW-1:0] a, input logic [MW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [MW-1:0] dist;
  logic [3:0]    dec_conf;

  always_comb begin
    dist = '0;
    case (sel1)
      SCH_BPSK: dist = ai_w;
      SCH_QPSK: dist = min2(ai_w, aq_w);
      SCH_8PSK: dist = min2(abs_diff(ai_w, aq_x2), abs_diff(ai_x2, aq_w));
      default:  dist = min2(min2(ai_w, abs_diff(ai_w, QAM_M)),
                            min2(aq_w, abs_diff(aq_w, QAM_M)));
    endcase
    dec_conf = (dist > MW'(15)) ? 4'd15 : dist[3:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      bits_out  <= '0;
      nbits_out <= '0;
      sym_cnt   <= '0;
`ifdef SOFT_METRIC_EN
      conf_out  <= '0;
`endif
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          bits_out  <= dec_bits;
          nbits_out <= dec_nbits;
`ifdef SOFT_METRIC_EN
          conf_out  <= dec_conf;
`endif
        end
      end
      if (v2 && out_ready) sym_cnt <= sym_cnt + CNT_W'(1);
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_all_demod.sv
// Self-checking bench for all_demod: vector table, scheme streams, stall,
// mid-stream reset and counter wrap, with an expected-result queue.
module tb_all_demod;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        select;
  logic signed [3:0] i_in, q_in;
  logic              in_valid, in_ready;
  logic [3:0]        bits_out;
  logic [2:0]        nbits_out;
  logic              out_valid, out_ready;
  logic [CNT_W-1:0]  sym_cnt;
`ifdef SOFT_METRIC_EN
  logic [3:0]        conf_out;
`endif

  all_demod #(.DATA_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .select(select), .i_in(i_in), .q_in(q_in),
    .in_valid(in_valid), .in_ready(in_ready), .bits_out(bits_out),
    .nbits_out(nbits_out), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SOFT_METRIC_EN
    .conf_out(conf_out),
`endif
    .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bits;
    logic [2:0] nbits;
    logic [3:0] conf;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    int         i;
    int         q;
    logic [3:0] bits;
    logic [2:0] nbits;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int qam_pair(input int x);
    if (x >= 4) return 2;
    if (x >= 0) return 3;
    if (x >= -4) return 1;
    return 0;
  endfunction

  function automatic exp_t model(input logic [1:0] sel, input int i, input int q);
    exp_t e;
    int ai, aq, k, c;
    ai = iabs(i);
    aq = iabs(q);
    k = 0;
    case (sel)
      2'd0: begin
        e.bits = (i < 0) ? 4'd1 : 4'd0; e.nbits = 3'd1; c = ai;
      end
      2'd1: begin
        e.bits = 4'((i < 0) * 2 + (q < 0)); e.nbits = 3'd2; c = imin(ai, aq);
      end
      2'd2: begin
        if (2 * aq <= ai) k = (i >= 0) ? 0 : 4;
        else if (2 * ai <= aq) k = (q >= 0) ? 2 : 6;
        else if (i >= 0) k = (q >= 0) ? 1 : 7;
        else k = (q >= 0) ? 3 : 5;
        e.bits = 4'(k ^ (k >> 1)); e.nbits = 3'd3;
        c = imin(iabs(ai - 2 * aq), iabs(2 * ai - aq));
      end
      default: begin
        e.bits = 4'(qam_pair(i) * 4 + qam_pair(q)); e.nbits = 3'd4;
        c = imin(imin(ai, iabs(ai - 4)), imin(aq, iabs(aq - 4)));
      end
    endcase
    e.conf = 4'((c > 15) ? 15 : c);
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, score both handshakes.
  task automatic step(input logic iv, input logic [1:0] s, input int i, input int q,
                      input logic ordy, input exp_t e, output logic acc);
    exp_t got;
    @(negedge clk);
    in_valid  = iv;
    select    = s;
    i_in      = i[3:0];
    q_in      = q[3:0];
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        got = sb.pop_front();
        check("bits_out", {28'd0, bits_out}, {28'd0, got.bits});
        check("nbits_out", {29'd0, nbits_out}, {29'd0, got.nbits});
        check("sym_cnt", {28'd0, sym_cnt}, 32'(exp_cnt));
`ifdef SOFT_METRIC_EN
        check("conf_out", {28'd0, conf_out}, {28'd0, got.conf});
`endif
      end
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    end
    acc = iv && in_ready;
    if (acc) sb.push_back(e);
  endtask

  task automatic idle(input int n);
    logic acc;
    exp_t z;
    z = '0;
    for (int c = 0; c < n; c++) step(1'b0, 2'd0, 0, 0, 1'b1, z, acc);
  endtask

  vec_t       vt[16];
  logic [1:0] hs_sel[7];
  int         hs_i[7], hs_q[7];

  initial begin
    logic       acc;
    exp_t       e;
    int         idx, nvalid, first_valid, guard;
    logic [3:0] held_bits;
    logic [2:0] held_nbits;
    logic [CNT_W-1:0] held_cnt;
    logic [1:0] rs;
    int         ri, rq;
    logic       rv;

    vt[0]  = '{2'd0, -3,  0, 4'b0001, 3'd1};
    vt[1]  = '{2'd1,  3, -3, 4'b0001, 3'd2};
    vt[2]  = '{2'd2,  5,  5, 4'b0001, 3'd3};
    vt[3]  = '{2'd2, -6,  1, 4'b0110, 3'd3};
    vt[4]  = '{2'd2,  0,  0, 4'b0000, 3'd3};
    vt[5]  = '{2'd3,  5, -2, 4'b1001, 3'd4};
    vt[6]  = '{2'd3, -8,  3, 4'b0011, 3'd4};
    vt[7]  = '{2'd0,  0,  7, 4'b0000, 3'd1};
    vt[8]  = '{2'd1, -8, -8, 4'b0011, 3'd2};
    vt[9]  = '{2'd2,  4,  2, 4'b0000, 3'd3};
    vt[10] = '{2'd2,  2, -4, 4'b0101, 3'd3};
    vt[11] = '{2'd2, -3, -3, 4'b0111, 3'd3};
    vt[12] = '{2'd2, -8,  7, 4'b0010, 3'd3};
    vt[13] = '{2'd3,  4, -4, 4'b1001, 3'd4};
    vt[14] = '{2'd3, -4, -5, 4'b0100, 3'd4};
    vt[15] = '{2'd1,  2, -5, 4'b0001, 3'd2};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; select = 2'd0; i_in = '0; q_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bits_out", {28'd0, bits_out}, 32'd0);
    check("rst_nbits_out", {29'd0, nbits_out}, 32'd0);
    check("rst_sym_cnt", {28'd0, sym_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Vector table, back to back
    for (int n = 0; n < 16; n++) begin
      e = model(vt[n].sel, vt[n].i, vt[n].q);
      e.bits  = vt[n].bits;
      e.nbits = vt[n].nbits;
      step(1'b1, vt[n].sel, vt[n].i, vt[n].q, 1'b1, e, acc);
      check("table_accept", {31'd0, acc}, 32'd1);
    end
    idle(3);
    check("table_drained", 32'(sb.size()), 32'd0);

    // Eight symbols with select changing every cycle: latency 2, no gaps
    nvalid = 0; first_valid = -1;
    for (int n = 0; n < 10; n++) begin
      rs = 2'(n);
      ri = $urandom_range(15) - 8;
      rq = $urandom_range(15) - 8;
      rv = (n < 8);
      step(rv, rs, ri, rq, 1'b1, model(rs, ri, rq), acc);
      if (out_valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = n;
      end
    end
    check("stream_first_valid_cycle", 32'(first_valid), 32'd2);
    check("stream_valid_cycles", 32'(nvalid), 32'd8);
    idle(2);

    // Stall: out_ready low for 5 cycles while offering symbols
    for (int n = 0; n < 7; n++) begin
      hs_sel[n] = 2'($urandom_range(3));
      hs_i[n]   = $urandom_range(15) - 8;
      hs_q[n]   = $urandom_range(15) - 8;
    end
    idx = 0;
    held_bits = '0; held_nbits = '0; held_cnt = '0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, hs_sel[idx], hs_i[idx], hs_q[idx], 1'b0,
           model(hs_sel[idx], hs_i[idx], hs_q[idx]), acc);
      if (acc) idx++;
      if (c == 2) begin
        held_bits = bits_out; held_nbits = nbits_out; held_cnt = sym_cnt;
      end else if (c > 2) begin
        check("stall_bits_stable", {28'd0, bits_out}, {28'd0, held_bits});
        check("stall_nbits_stable", {29'd0, nbits_out}, {29'd0, held_nbits});
        check("stall_cnt_stable", {28'd0, sym_cnt}, {28'd0, held_cnt});
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
      end
    end
    check("stall_accepted", 32'(idx), 32'd2);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    guard = 0;
    while (idx < 7 && guard < 50) begin
      step(1'b1, hs_sel[idx], hs_i[idx], hs_q[idx], 1'b1,
           model(hs_sel[idx], hs_i[idx], hs_q[idx]), acc);
      if (acc) idx++;
      guard++;
    end
    check("release_all_sent", 32'(idx), 32'd7);
    idle(3);
    check("release_none_lost", 32'(sb.size()), 32'd0);

    // Random valid / ready traffic, samples held until accepted
    rs = 2'($urandom_range(3)); ri = $urandom_range(15) - 8; rq = $urandom_range(15) - 8;
    for (int c = 0; c < 300; c++) begin
      rv = ($urandom_range(3) != 0);
      step(rv, rs, ri, rq, ($urandom_range(2) != 0), model(rs, ri, rq), acc);
      if (acc) begin
        rs = 2'($urandom_range(3)); ri = $urandom_range(15) - 8; rq = $urandom_range(15) - 8;
      end
    end
    idle(4);
    check("random_drained", 32'(sb.size()), 32'd0);

    // Reset with two symbols in flight
    for (int n = 0; n < 2; n++) step(1'b1, 2'd3, 5, 5, 1'b0, model(2'd3, 5, 5), acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sym_cnt", {28'd0, sym_cnt}, 32'd0);
    sb.delete();
    exp_cnt = 0;
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      if (out_valid) nvalid++;
    end
    check("midrst_no_stale", 32'(nvalid), 32'd0);

    // 17 symbols: 4-bit counter wraps 15 -> 0 -> 1
    for (int n = 0; n < 17; n++) begin
      rs = 2'($urandom_range(3)); ri = $urandom_range(15) - 8; rq = $urandom_range(15) - 8;
      step(1'b1, rs, ri, rq, 1'b1, model(rs, ri, rq), acc);
    end
    idle(3);
    check("wrap_final_cnt", {28'd0, sym_cnt}, 32'd1);
    check("wrap_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
